// File: rtl/register_write_sequencer.sv
// Request FIFO feeding a write-once config register: one strobe per request, spaced
// by a fixed idle gap, with a shadow lock that turns later requests into counted drops.
module register_write_sequencer #(
  parameter int DATA_WIDTH = 16,
  parameter int FIFO_DEPTH = 4,
  parameter int GAP_CYCLES = 1
) (
  input  logic                  Clk,
  input  logic                  ip_reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [DATA_WIDTH-1:0] req_data,
  output logic                  write,
  output logic [DATA_WIDTH-1:0] wr_data,
  output logic                  locked,
  output logic                  reject,
  output logic [7:0]            reject_count,
  output logic                  busy
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GW-1:0] GAP_INIT = (GAP_CYCLES > 0) ? GW'(GAP_CYCLES - 1) : '0;

  typedef enum logic [1:0] {IDLE, WRITE, GAP} state_t;

  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]         wptr_q, rptr_q;
  logic [CW-1:0]         cnt_q, cnt_d;
  state_t                state_q, state_d;
  logic [GW-1:0]         gap_q, gap_d;
  logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
  logic                  locked_q, locked_d;
  logic                  reject_q, reject_d;
  logic [7:0]            rcnt_q, rcnt_d;
  logic                  full, empty, push, pop;

  assign full  = (cnt_q == CW'(FIFO_DEPTH));
  assign empty = (cnt_q == '0);
  // Full blocks the push even when the FSM pops in the same cycle.
  assign push  = req_valid & ~full;

  always_comb begin
    state_d   = state_q;
    gap_d     = gap_q;
    wr_data_d = wr_data_q;
    locked_d  = locked_q;
    reject_d  = 1'b0;
    rcnt_d    = rcnt_q;
    pop       = 1'b0;
    case (state_q)
      IDLE: begin
        if (!empty) begin
          pop = 1'b1;
          if (locked_q) begin
            reject_d = 1'b1;
            if (rcnt_q != 8'hFF) rcnt_d = rcnt_q + 8'd1;
          end else begin
            wr_data_d = mem_q[rptr_q];
            state_d   = WRITE;
          end
        end
      end
      WRITE: begin
        locked_d = locked_q | wr_data_q[0];
        if (GAP_CYCLES == 0) begin
          state_d = IDLE;
        end else begin
          state_d = GAP;
          gap_d   = GAP_INIT;
        end
      end
      GAP: begin
        if (gap_q == '0) state_d = IDLE;
        else             gap_d   = gap_q - GW'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cnt_d = cnt_q;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (push) mem_q[wptr_q] <= req_data;
  end

  always_ff @(posedge Clk) begin
    if (ip_reset) begin
      wptr_q    <= '0;
      rptr_q    <= '0;
      cnt_q     <= '0;
      state_q   <= IDLE;
      gap_q     <= '0;
      wr_data_q <= '0;
      locked_q  <= 1'b0;
      reject_q  <= 1'b0;
      rcnt_q    <= '0;
    end else begin
      if (push) wptr_q <= wptr_q + AW'(1);
      if (pop)  rptr_q <= rptr_q + AW'(1);
      cnt_q     <= cnt_d;
      state_q   <= state_d;
      gap_q     <= gap_d;
      wr_data_q <= wr_data_d;
      locked_q  <= locked_d;
      reject_q  <= reject_d;
      rcnt_q    <= rcnt_d;
    end
  end

  assign req_ready    = ~full;
  assign write        = (state_q == WRITE);
  assign wr_data      = wr_data_q;
  assign locked       = locked_q;
  assign reject       = reject_q;
  assign reject_count = rcnt_q;
  assign busy         = ~empty | (state_q != IDLE);
endmodule
